// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: holds one load/store stable toward mem_system until Done, stalls the pipeline, tracks stats, errors and the halt dump
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic        req_halt,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_CacheHit,
  input  logic        mem_err,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        mem_Rd,
  output logic        mem_Wr,
  output logic        mem_createdump,
  output logic        stall_out,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        err_out,
  output logic        halted,
  output logic [15:0] access_count,
  output logic [15:0] hit_count
);
  typedef enum logic [1:0] {IDLE, BUSY, DUMP, HALTED} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, acc_q, acc_d, hit_q, hit_d;
  logic [7:0] wait_q, wait_d;
  logic is_load_q, is_load_d, rv_q, rv_d, err_q, err_d;
  logic idle, busy, dump, accept, halt_go, bad_req, done, timeout;
  always_comb begin
    idle    = state_q == IDLE;
    busy    = state_q == BUSY;
    dump    = state_q == DUMP;
    halt_go = idle & req_valid & req_halt;
    accept  = idle & req_valid & !req_halt & (req_load ^ req_store) & !req_addr[0] & !err_q;
    bad_req = idle & req_valid & !req_halt & ((req_load & req_store) | ((req_load | req_store) & req_addr[0]));
    done    = busy & mem_Done;
    timeout = busy & !mem_Done & (wait_q == WAIT_LAST);
    state_d = halt_go ? DUMP : accept ? BUSY : (done | timeout) ? IDLE : dump ? HALTED : state_q;
    addr_d    = accept ? req_addr : addr_q;
    wdata_d   = accept ? req_wdata : wdata_q;
    is_load_d = accept ? req_load : is_load_q;
    wait_d    = accept ? 8'd0 : (busy & !mem_Done) ? wait_q + 8'd1 : wait_q;
    rdata_d   = (done & is_load_q) ? mem_DataOut : rdata_q;
    rv_d      = done & is_load_q;
    err_d     = err_q | mem_err | bad_req | timeout;
    // saturate rather than wrap
    acc_d     = (done & (acc_q != 16'hFFFF)) ? acc_q + 16'd1 : acc_q;
    hit_d     = (done & mem_CacheHit & (hit_q != 16'hFFFF)) ? hit_q + 16'd1 : hit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      wait_q    <= '0;
      rdata_q   <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= '0;
      hit_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      hit_q     <= hit_d;
    end
  end
  assign mem_Addr       = addr_q;
  assign mem_DataIn     = wdata_q;
  assign mem_Rd         = busy & is_load_q;
  assign mem_Wr         = busy & !is_load_q;
  assign mem_createdump = dump;
  assign stall_out      = accept | (busy & !mem_Done) | halt_go | dump;
  assign rdata          = rdata_q;
  assign rdata_valid    = rv_q;
  assign err_out        = err_q;
  assign halted         = state_q == HALTED;
  assign access_count   = acc_q;
  assign hit_count      = hit_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scenario tests for mem_stage_ctrl with hand-computed expectations
module tb_mem_stage_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid, req_load, req_store, req_halt;
  logic [15:0] req_addr, req_wdata, mem_DataOut;
  logic mem_Done, mem_CacheHit, mem_err;
  logic [15:0] mem_Addr, mem_DataIn, rdata, access_count, hit_count;
  logic mem_Rd, mem_Wr, mem_createdump, stall_out, rdata_valid, err_out, halted;
  int n_cmp = 0, n_bad = 0;
  mem_stage_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_halt(req_halt), .req_addr(req_addr), .req_wdata(req_wdata), .mem_DataOut(mem_DataOut),
    .mem_Done(mem_Done), .mem_CacheHit(mem_CacheHit), .mem_err(mem_err), .mem_Addr(mem_Addr),
    .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_createdump(mem_createdump),
    .stall_out(stall_out), .rdata(rdata), .rdata_valid(rdata_valid), .err_out(err_out),
    .halted(halted), .access_count(access_count), .hit_count(hit_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in();
    req_valid = 0; req_load = 0; req_store = 0; req_halt = 0; req_addr = 0; req_wdata = 0;
    mem_DataOut = 0; mem_Done = 0; mem_CacheHit = 0; mem_err = 0;
  endtask
  task automatic do_reset();
    clr_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    clr_in();
    req_addr = 16'hFFFF; req_wdata = 16'hFFFF; mem_DataOut = 16'hFFFF; mem_Done = 1; mem_CacheHit = 1;
    rst = 1;
    tick();
    tick();
    clr_in();
    #1;
    n_cmp++; if ({mem_Addr, mem_DataIn, rdata, access_count, hit_count} !== 80'h0) begin n_bad++; $display("FAIL reset_words: got %h want 0", {mem_Addr, mem_DataIn, rdata, access_count, hit_count}); end
    n_cmp++; if ({mem_Rd, mem_Wr, mem_createdump, stall_out, rdata_valid, err_out, halted} !== 7'h0) begin n_bad++; $display("FAIL reset_bits: got %b want 0", {mem_Rd, mem_Wr, mem_createdump, stall_out, rdata_valid, err_out, halted}); end
    rst = 0;
    tick();
  endtask
  task automatic test_load_hit();
    do_reset();
    req_valid = 1; req_load = 1; req_addr = 16'h0010;
    #1;
    n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL hit_stall_accept: got %b want 1", stall_out); end
    n_cmp++; if (mem_Rd !== 1'b0) begin n_bad++; $display("FAIL hit_rd_accept: got %b want 0", mem_Rd); end
    tick();
    clr_in(); mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'hBEEF;
    #1;
    n_cmp++; if ({mem_Rd, mem_Wr} !== 2'b10) begin n_bad++; $display("FAIL hit_rdwr_busy: got %b want 10", {mem_Rd, mem_Wr}); end
    n_cmp++; if (mem_Addr !== 16'h0010) begin n_bad++; $display("FAIL hit_addr: got %h want 0010", mem_Addr); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL hit_stall_done: got %b want 0", stall_out); end
    n_cmp++; if (rdata_valid !== 1'b0) begin n_bad++; $display("FAIL hit_rv_early: got %b want 0", rdata_valid); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (rdata_valid !== 1'b1) begin n_bad++; $display("FAIL hit_rv: got %b want 1", rdata_valid); end
    n_cmp++; if (rdata !== 16'hBEEF) begin n_bad++; $display("FAIL hit_rdata: got %h want beef", rdata); end
    n_cmp++; if ({access_count, hit_count} !== {16'd1, 16'd1}) begin n_bad++; $display("FAIL hit_counts: got %0d/%0d want 1/1", access_count, hit_count); end
    n_cmp++; if (mem_Rd !== 1'b0) begin n_bad++; $display("FAIL hit_rd_after: got %b want 0", mem_Rd); end
    tick();
    #1;
    n_cmp++; if ({rdata_valid, rdata} !== {1'b0, 16'hBEEF}) begin n_bad++; $display("FAIL hit_rv_hold: got %b/%h want 0/beef", rdata_valid, rdata); end
  endtask
  task automatic test_store_miss();
    int stalls;
    do_reset();
    stalls = 0;
    req_valid = 1; req_store = 1; req_addr = 16'h0020; req_wdata = 16'h1234;
    #1;
    if (stall_out) stalls++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      clr_in(); mem_Done = (k == 5); mem_DataOut = 16'hDEAD;
      #1;
      if (stall_out) stalls++;
      n_cmp++; if ({mem_Rd, mem_Wr, mem_Addr, mem_DataIn} !== {2'b01, 16'h0020, 16'h1234}) begin n_bad++; $display("FAIL st_stable_c%0d: got %b%b %h %h want 01 0020 1234", k, mem_Rd, mem_Wr, mem_Addr, mem_DataIn); end
      n_cmp++; if (stall_out !== (k != 5)) begin n_bad++; $display("FAIL st_stall_c%0d: got %b want %b", k, stall_out, k != 5); end
    end
    n_cmp++; if (stalls != 5) begin n_bad++; $display("FAIL st_stall_total: got %0d want 5", stalls); end
    tick();
    clr_in();
    #1;
    n_cmp++; if ({mem_Wr, rdata_valid, rdata} !== {1'b0, 1'b0, 16'h0000}) begin n_bad++; $display("FAIL st_after: got %b %b %h want 0 0 0000", mem_Wr, rdata_valid, rdata); end
    n_cmp++; if ({access_count, hit_count} !== {16'd1, 16'd0}) begin n_bad++; $display("FAIL st_counts: got %0d/%0d want 1/0", access_count, hit_count); end
    n_cmp++; if (mem_Addr !== 16'h0020) begin n_bad++; $display("FAIL st_addr_hold: got %h want 0020", mem_Addr); end
  endtask
  task automatic test_misaligned();
    do_reset();
    req_valid = 1; req_load = 1; req_addr = 16'h0011;
    #1;
    n_cmp++; if ({stall_out, mem_Rd} !== 2'b00) begin n_bad++; $display("FAIL mis_stall_rd: got %b want 00", {stall_out, mem_Rd}); end
    tick();
    clr_in();
    #1;
    n_cmp++; if ({err_out, mem_Rd} !== 2'b10) begin n_bad++; $display("FAIL mis_err: got %b want 10", {err_out, mem_Rd}); end
    req_valid = 1; req_load = 1; req_addr = 16'h0012;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({mem_Rd, stall_out} !== 2'b00) begin n_bad++; $display("FAIL mis_blocked_c%0d: got %b want 00", k, {mem_Rd, stall_out}); end
      tick();
    end
    clr_in();
    #1;
    n_cmp++; if ({access_count, err_out} !== {16'd0, 1'b1}) begin n_bad++; $display("FAIL mis_count: got %0d err %b want 0 err 1", access_count, err_out); end
    req_valid = 1; req_halt = 1;
    tick();
    clr_in();
    #1;
    n_cmp++; if (mem_createdump !== 1'b1) begin n_bad++; $display("FAIL mis_halt_ok: got %b want 1", mem_createdump); end
  endtask
  task automatic test_both_flags();
    do_reset();
    req_valid = 1; req_load = 1; req_store = 1; req_addr = 16'h0040;
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL both_stall: got %b want 0", stall_out); end
    tick();
    clr_in();
    #1;
    n_cmp++; if ({err_out, mem_Rd, mem_Wr} !== 3'b100) begin n_bad++; $display("FAIL both_err: got %b want 100", {err_out, mem_Rd, mem_Wr}); end
  endtask
  task automatic test_mem_err();
    do_reset();
    req_valid = 1; req_load = 1; req_addr = 16'h0030;
    tick();
    clr_in(); mem_Done = 1; mem_err = 1; mem_DataOut = 16'h4242;
    tick();
    clr_in();
    #1;
    n_cmp++; if ({err_out, rdata_valid, rdata, access_count} !== {1'b1, 1'b1, 16'h4242, 16'd1}) begin n_bad++; $display("FAIL merr: got %b %b %h %0d want 1 1 4242 1", err_out, rdata_valid, rdata, access_count); end
  endtask
  task automatic test_timeout();
    do_reset();
    req_valid = 1; req_store = 1; req_addr = 16'h0030; req_wdata = 16'h5555;
    tick();
    clr_in();
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_cmp++; if ({mem_Wr, stall_out, err_out} !== 3'b110) begin n_bad++; $display("FAIL to_busy_c%0d: got %b want 110", k, {mem_Wr, stall_out, err_out}); end
      tick();
    end
    #1;
    n_cmp++; if ({mem_Wr, mem_Rd, err_out, rdata_valid, stall_out} !== 5'b00100) begin n_bad++; $display("FAIL to_end: got %b want 00100", {mem_Wr, mem_Rd, err_out, rdata_valid, stall_out}); end
    n_cmp++; if ({access_count, hit_count} !== 32'h0) begin n_bad++; $display("FAIL to_counts: got %0d/%0d want 0/0", access_count, hit_count); end
    mem_Done = 1; mem_CacheHit = 1;
    tick();
    clr_in();
    #1;
    n_cmp++; if ({access_count, hit_count} !== 32'h0) begin n_bad++; $display("FAIL to_idle_done: got %0d/%0d want 0/0", access_count, hit_count); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    req_valid = 1; req_load = 1; req_addr = 16'h0010;
    tick();
    clr_in(); mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'h1111;
    tick();
    clr_in(); req_valid = 1; req_load = 1; req_addr = 16'h0012;
    #1;
    n_cmp++; if ({stall_out, rdata_valid, rdata} !== {1'b1, 1'b1, 16'h1111}) begin n_bad++; $display("FAIL b2b_accept: got %b %b %h want 1 1 1111", stall_out, rdata_valid, rdata); end
    tick();
    clr_in(); mem_Done = 1; mem_DataOut = 16'h2222;
    #1;
    n_cmp++; if ({mem_Rd, mem_Addr, rdata_valid} !== {1'b1, 16'h0012, 1'b0}) begin n_bad++; $display("FAIL b2b_busy: got %b %h %b want 1 0012 0", mem_Rd, mem_Addr, rdata_valid); end
    tick();
    clr_in();
    #1;
    n_cmp++; if ({rdata, access_count, hit_count} !== {16'h2222, 16'd2, 16'd1}) begin n_bad++; $display("FAIL b2b_end: got %h %0d/%0d want 2222 2/1", rdata, access_count, hit_count); end
  endtask
  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_valid = 1; req_load = 1; req_addr = 16'h0100 + 16'(2 * i);
      tick();
      clr_in(); mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'hA000 + 16'(i);
      tick();
      clr_in();
    end
    req_valid = 1; req_halt = 1; req_load = 1; req_addr = 16'h0200;
    #1;
    n_cmp++; if ({stall_out, mem_Rd, mem_createdump} !== 3'b100) begin n_bad++; $display("FAIL halt_req: got %b want 100", {stall_out, mem_Rd, mem_createdump}); end
    tick();
    clr_in();
    #1;
    n_cmp++; if ({mem_createdump, stall_out, halted, mem_Rd} !== 4'b1100) begin n_bad++; $display("FAIL halt_dump: got %b want 1100", {mem_createdump, stall_out, halted, mem_Rd}); end
    tick();
    req_valid = 1; req_load = 1; req_addr = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({mem_createdump, stall_out, halted, mem_Rd} !== 4'b0010) begin n_bad++; $display("FAIL halt_inert_c%0d: got %b want 0010", k, {mem_createdump, stall_out, halted, mem_Rd}); end
      tick();
    end
    clr_in();
    #1;
    n_cmp++; if ({access_count, hit_count, rdata} !== {16'd2, 16'd2, 16'hA001}) begin n_bad++; $display("FAIL halt_counts: got %0d/%0d %h want 2/2 a001", access_count, hit_count, rdata); end
  endtask
  task automatic test_rst_mid_busy();
    do_reset();
    req_valid = 1; req_load = 1; req_addr = 16'h0050;
    tick();
    clr_in();
    #1;
    n_cmp++; if (mem_Rd !== 1'b1) begin n_bad++; $display("FAIL rb_busy: got %b want 1", mem_Rd); end
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_cmp++; if ({mem_Rd, mem_Wr, stall_out, err_out, rdata_valid, halted, mem_createdump} !== 7'h0) begin n_bad++; $display("FAIL rb_bits: got %b want 0", {mem_Rd, mem_Wr, stall_out, err_out, rdata_valid, halted, mem_createdump}); end
    n_cmp++; if ({mem_Addr, access_count, hit_count} !== 48'h0) begin n_bad++; $display("FAIL rb_words: got %h %0d %0d want 0 0 0", mem_Addr, access_count, hit_count); end
    req_valid = 1; req_load = 1; req_addr = 16'h0060;
    tick();
    clr_in(); mem_Done = 1; mem_CacheHit = 1; mem_DataOut = 16'h7777;
    tick();
    clr_in();
    #1;
    n_cmp++; if ({rdata_valid, rdata, access_count, hit_count} !== {1'b1, 16'h7777, 16'd1, 16'd1}) begin n_bad++; $display("FAIL rb_fresh: got %b %h %0d/%0d want 1 7777 1/1", rdata_valid, rdata, access_count, hit_count); end
  endtask
  initial begin
    clr_in();
    test_reset();
    test_load_hit();
    test_store_miss();
    test_misaligned();
    test_both_flags();
    test_mem_err();
    test_timeout();
    test_back_to_back();
    test_halt();
    test_rst_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Pipeline memory-stage request controller that sits directly upstream of `mem_system` and drives its `Addr`/`DataIn`/`Rd`/`Wr`/`createdump` inputs. It latches one load or store from the EX/MEM latch and holds it stable until `mem_system` raises `Done`. It freezes the upstream pipeline while the access is outstanding, returns load data with a valid pulse, and keeps hit/access statistics. It also flags misaligned accesses, illegal requests, memory errors and timeouts, and sequences the end-of-program dump.

## Interface
- TIMEOUT, 64, maximum cycles in BUSY before the request is abandoned (2..255)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  EX/MEM latch holds a valid instruction
- req_load  in  1  instruction is a load
- req_store  in  1  instruction is a store
- req_halt  in  1  instruction is HALT
- req_addr  in  16  effective address
- req_wdata  in  16  store data
- mem_DataOut  in  16  `mem_system` DataOut
- mem_Done  in  1  `mem_system` Done
- mem_CacheHit  in  1  `mem_system` CacheHit
- mem_err  in  1  `mem_system` err
- mem_Addr  out  16  to `mem_system` Addr
- mem_DataIn  out  16  to `mem_system` DataIn
- mem_Rd  out  1  to `mem_system` Rd
- mem_Wr  out  1  to `mem_system` Wr
- mem_createdump  out  1  to `mem_system` createdump
- stall_out  out  1  freeze EX/MEM and all earlier stages
- rdata  out  16  last completed load data, held until the next load completes
- rdata_valid  out  1  one-cycle pulse when a load completes
- err_out  out  1  sticky error, cleared only by rst
- halted  out  1  dump complete; the stage is inert
- access_count  out  16  completed accesses, saturating
- hit_count  out  16  completed accesses with `CacheHit`, saturating

## Operation
- States: IDLE, BUSY, DUMP, HALTED. Reset → IDLE.
- Reset values: all outputs 0; internal request registers 0; wait counter 0.
- The request is accepted in IDLE when `req_valid & (req_load ^ req_store)` is true, `req_addr[0]==0`, and `err_out==0`.
  - On acceptance, latch addr, wdata and type, then go to BUSY.
- `mem_Addr`, `mem_DataIn`, `mem_Rd` and `mem_Wr` are driven from the latched registers only.
  - In BUSY, exactly one of `mem_Rd`/`mem_Wr` is 1.
  - Outside BUSY, `mem_Rd`=`mem_Wr`=0; `mem_Addr`/`mem_DataIn` hold their last values.
- In BUSY, when `mem_Done`=1:
  - For a load, `rdata`←`mem_DataOut` and `rdata_valid` pulses the next cycle.
  - `access_count`+1; `hit_count`+1 if `mem_CacheHit`.
  - Return to IDLE.
- `stall_out` = (IDLE & acceptable request) | (BUSY & !`mem_Done`) | (IDLE & `req_valid` & `req_halt`) | DUMP.
  - It is 0 in the Done cycle so the pipeline advances on that edge.
- Error conditions, all setting `err_out` (sticky); the request is discarded and no memory access is issued:
  - A misaligned access (`req_addr[0]`=1 with load or store).
  - `req_load & req_store` both 1.
- `mem_err`=1 in any cycle sets `err_out`; the FSM continues normally.
- Timeout: the wait counter clears on entry to BUSY and increments each BUSY cycle without Done.
  - On reaching TIMEOUT, set `err_out` and go to IDLE with `mem_Rd`/`mem_Wr` deasserted.
  - No counters change and no `rdata_valid` is issued.
- `req_halt` in IDLE with `req_valid`: go to DUMP. DUMP asserts `mem_createdump` for exactly one cycle, then goes to HALTED.
  - HALTED is absorbing: `halted`=1, `stall_out`=0, and all requests are ignored.
- `req_halt` takes priority over load/store flags in the same cycle.
- While `err_out`=1, IDLE accepts no load/store; HALT is still honoured.
- Counters saturate at 0xFFFF; wrap-around is forbidden.

## Timing
- Minimum access latency is 2 cycles: accept edge, then BUSY cycle with Done (a cache hit). `stall_out` is high for 1 cycle.
- For a miss with Done in BUSY cycle N, `stall_out` is high for N cycles.
- `rdata_valid` is registered: high in the cycle after the Done cycle, for 1 cycle.
- Back-to-back accesses: a new request can be accepted in the cycle following Done, so the throughput is 1 access per 2 cycles for hits.
- `mem_Rd`/`mem_Wr`/`mem_Addr` are stable for every cycle of BUSY; the bench checks this each cycle.
- rst asserted mid-BUSY: the next cycle is IDLE with all outputs 0, and no partial counter update occurs.
- `mem_Done` outside BUSY is ignored.

## Test plan
- Load 0x0010, Done in first BUSY cycle with CacheHit=1, DataOut=0xBEEF → stall_out high 1 cycle; rdata=0xBEEF with rdata_valid pulse one cycle later; access_count=1, hit_count=1.
- Store 0x0020←0x1234, Done after 5 BUSY cycles, CacheHit=0 → mem_Wr=1, mem_Addr=0x0020, mem_DataIn=0x1234 stable for 5 cycles; stall_out high 5 cycles; hit_count=0, no rdata_valid.
- Load at 0x0011 → err_out=1 next cycle; mem_Rd never asserted; subsequent valid load at 0x0012 not accepted.
- TIMEOUT=8, store with Done held 0 → mem_Wr deasserted after 8 BUSY cycles; err_out=1; access_count unchanged.
- HALT after two hits → mem_createdump high exactly 1 cycle; halted=1 thereafter; a later load produces no mem_Rd; access_count=2, hit_count=2.
- rst asserted in 3rd BUSY cycle of a miss → all outputs 0 next cycle; a fresh load then completes normally with access_count=1.
